// File: rtl/hilo_file_pkg.sv
// Shared widths, reset/write polarity and FSM encoding for the HI/LO register pair.
// Latency: n/a (definitions only); backpressure: n/a.
package hilo_file_pkg;
    localparam int RegBus = 32;

    localparam logic RstEnable    = 1'b1;
    localparam logic WriteEnable  = 1'b1;
    localparam logic WriteDisable = 1'b0;

    localparam logic [0:0] HILO_IDLE = 1'b0;
    localparam logic [0:0] HILO_PEND = 1'b1;

    typedef logic [RegBus-1:0] reg_t;

    typedef struct packed {
        reg_t hi;
        reg_t lo;
    } hilo_t;
endpackage

// File: rtl/hilo_file_if.sv
// Pipeline-side bundle of HI/LO write ports, divider handshake and read/stall outputs.
// Latency: n/a (wiring only); backpressure: divider result held until div_ack_o.
interface hilo_file_if;
    import hilo_file_pkg::*;

    logic we1_i;
    reg_t hi1_i, lo1_i;
    logic we2_i;
    reg_t hi2_i, lo2_i;
    logic div_start_i;
    logic div_valid_i;
    reg_t div_hi_i, div_lo_i;
    logic div_ack_o;
    logic flush_i;
    logic rd_req_i;
    reg_t hi_o, lo_o;
    logic stall_req_o;
    logic busy_o;

    modport master (
        output we1_i, hi1_i, lo1_i, we2_i, hi2_i, lo2_i,
        output div_start_i, div_valid_i, div_hi_i, div_lo_i, flush_i, rd_req_i,
        input  div_ack_o, hi_o, lo_o, stall_req_o, busy_o
    );

    modport slave (
        input  we1_i, hi1_i, lo1_i, we2_i, hi2_i, lo2_i,
        input  div_start_i, div_valid_i, div_hi_i, div_lo_i, flush_i, rd_req_i,
        output div_ack_o, hi_o, lo_o, stall_req_o, busy_o
    );
endinterface

// File: rtl/hilo_file_fwd_mux.sv
// 3-source HI/LO priority select (slot 2 > slot 1 > divide commit > default).
// Latency: combinational; backpressure: none.
module hilo_fwd_mux
    import hilo_file_pkg::*;
(
    input  logic  en2_i,
    input  hilo_t dat2_i,
    input  logic  en1_i,
    input  hilo_t dat1_i,
    input  logic  en0_i,
    input  hilo_t dat0_i,
    input  hilo_t dflt_i,
    output hilo_t sel_o
);
    always_comb begin
        sel_o = dflt_i;
        if (en2_i) begin
            sel_o = dat2_i;
        end else if (en1_i) begin
            sel_o = dat1_i;
        end else if (en0_i) begin
            sel_o = dat0_i;
        end
    end
endmodule

// File: rtl/hilo_file.sv
// HI/LO register pair with one-outstanding-divide tracker; optional HILO_BYPASS_EN forwarding.
// Latency: writes visible next cycle (same cycle with bypass); stalls readers on a pending divide.
module hilo_file
    import hilo_file_pkg::*;
(
    input logic       clk,
    input logic       rst,
    hilo_file_if.slave bus
);
    logic [0:0] state_q, state_d;
    hilo_t      hilo_q, hilo_d;
    hilo_t      wr2_dat, wr1_dat, div_dat;
    logic       pend;
    logic       div_commit;

    assign pend       = (state_q == HILO_PEND);
    // A flush cancels the divide, so its result is acked but never written.
    assign div_commit = pend & bus.div_valid_i & ~bus.flush_i;

    assign wr2_dat = '{hi: bus.hi2_i,    lo: bus.lo2_i};
    assign wr1_dat = '{hi: bus.hi1_i,    lo: bus.lo1_i};
    assign div_dat = '{hi: bus.div_hi_i, lo: bus.div_lo_i};

    hilo_fwd_mux u_fwd (
        .en2_i  (bus.we2_i == WriteEnable),
        .dat2_i (wr2_dat),
        .en1_i  (bus.we1_i == WriteEnable),
        .dat1_i (wr1_dat),
        .en0_i  (div_commit),
        .dat0_i (div_dat),
        .dflt_i (hilo_q),
        .sel_o  (hilo_d)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            HILO_IDLE: if (bus.div_start_i) state_d = HILO_PEND;
            HILO_PEND: if (bus.flush_i || bus.div_valid_i) state_d = HILO_IDLE;
            default:   state_d = HILO_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q <= HILO_IDLE;
            hilo_q  <= '0;
        end else begin
            state_q <= state_d;
            hilo_q  <= hilo_d;
        end
    end

    // Every presented result is consumed: committed, flushed, or spurious.
    assign bus.div_ack_o = ~rst & bus.div_valid_i;
    assign bus.busy_o    = ~rst & pend;

`ifdef HILO_BYPASS_EN
    assign bus.hi_o        = rst ? hilo_q.hi : hilo_d.hi;
    assign bus.lo_o        = rst ? hilo_q.lo : hilo_d.lo;
    assign bus.stall_req_o = ~rst & pend & bus.rd_req_i & ~bus.div_valid_i;
`else
    assign bus.hi_o        = hilo_q.hi;
    assign bus.lo_o        = hilo_q.lo;
    assign bus.stall_req_o = ~rst & bus.rd_req_i & (pend | bus.we1_i | bus.we2_i);
`endif

    a_no_start_in_pend: assert property (@(posedge clk) disable iff (rst)
        !(pend && bus.div_start_i));
endmodule

// File: tb/tb_hilo_file.sv
// Scoreboarded random + directed bench for hilo_file against a rule-level HI/LO model.
module tb_hilo_file;
    import hilo_file_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hilo_file_if u_if ();

    hilo_file dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    typedef struct {
        logic rst;
        logic we1; reg_t hi1; reg_t lo1;
        logic we2; reg_t hi2; reg_t lo2;
        logic start; logic valid; reg_t dhi; reg_t dlo;
        logic flush; logic rd;
    } stim_t;

    typedef struct {
        logic ack; logic stall; logic busy;
        logic chk_data; reg_t hi; reg_t lo;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Architectural view: current HI/LO contents and whether a divide is outstanding.
    reg_t m_hi = '0;
    reg_t m_lo = '0;
    bit   m_pend = 1'b0;
    bit   m_prev_rst = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s.rst = 0; s.we1 = 0; s.hi1 = '0; s.lo1 = '0;
        s.we2 = 0; s.hi2 = '0; s.lo2 = '0;
        s.start = 0; s.valid = 0; s.dhi = '0; s.dlo = '0;
        s.flush = 0; s.rd = 0;
        return s;
    endfunction

    task automatic step(input stim_t s);
        exp_t e;
        reg_t nh, nl;
        bit   commit;
        @(posedge clk);
        #1;
        rst              = s.rst;
        u_if.we1_i       = s.we1;   u_if.hi1_i = s.hi1; u_if.lo1_i = s.lo1;
        u_if.we2_i       = s.we2;   u_if.hi2_i = s.hi2; u_if.lo2_i = s.lo2;
        u_if.div_start_i = s.start; u_if.div_valid_i = s.valid;
        u_if.div_hi_i    = s.dhi;   u_if.div_lo_i = s.dlo;
        u_if.flush_i     = s.flush; u_if.rd_req_i = s.rd;
        if (s.rst) begin
            e.ack = 0; e.stall = 0; e.busy = 0;
            e.chk_data = m_prev_rst;
            e.hi = '0; e.lo = '0;
            m_hi = '0; m_lo = '0; m_pend = 0;
        end else begin
            commit = m_pend && s.valid && !s.flush;
            nh = m_hi; nl = m_lo;
            if (commit) begin nh = s.dhi; nl = s.dlo; end
            if (s.we1)  begin nh = s.hi1; nl = s.lo1; end
            if (s.we2)  begin nh = s.hi2; nl = s.lo2; end
            e.ack      = s.valid;
            e.busy     = m_pend;
            e.chk_data = 1;
`ifdef HILO_BYPASS_EN
            e.hi = nh; e.lo = nl;
            e.stall = m_pend && s.rd && !s.valid;
`else
            e.hi = m_hi; e.lo = m_lo;
            e.stall = s.rd && (m_pend || s.we1 || s.we2);
`endif
            m_hi = nh; m_lo = nl;
            if (!m_pend)                 m_pend = s.start;
            else if (s.flush || s.valid) m_pend = 0;
        end
        m_prev_rst = s.rst;
        sb_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("div_ack",   32'(u_if.div_ack_o),   32'(e.ack));
                chk("stall_req", 32'(u_if.stall_req_o), 32'(e.stall));
                chk("busy",      32'(u_if.busy_o),      32'(e.busy));
                if (e.chk_data) begin
                    chk("hi_o", u_if.hi_o, e.hi);
                    chk("lo_o", u_if.lo_o, e.lo);
                end
            end
        end
    end

    initial begin : stimulus
        stim_t s;
        rst = 1'b1;
        u_if.we1_i = 0; u_if.hi1_i = '0; u_if.lo1_i = '0;
        u_if.we2_i = 0; u_if.hi2_i = '0; u_if.lo2_i = '0;
        u_if.div_start_i = 0; u_if.div_valid_i = 0;
        u_if.div_hi_i = '0; u_if.div_lo_i = '0;
        u_if.flush_i = 0; u_if.rd_req_i = 0;

        // Reset for two cycles with writes and divider activity present.
        s = idle(); s.rst = 1; s.we1 = 1; s.hi1 = 32'h55; s.lo1 = 32'h66;
        s.start = 1; s.valid = 1; s.rd = 1;
        step(s); step(s);

        // Dual write: slot 2 wins.
        s = idle(); s.we1 = 1; s.hi1 = 32'h11; s.lo1 = 32'h22;
        s.we2 = 1; s.hi2 = 32'h33; s.lo2 = 32'h44;
        step(s);
        s = idle(); s.rd = 1; step(s);

        // Divide with a reader waiting, result after 8 cycles.
        s = idle(); s.start = 1; s.rd = 1; step(s);
        s.start = 0; repeat (8) step(s);
        s.valid = 1; s.dhi = 32'h5; s.dlo = 32'h7; step(s);
        s = idle(); s.rd = 1; step(s);

        // Flush together with the result: acked but discarded.
        s = idle(); s.start = 1; step(s);
        s = idle(); step(s);
        s.flush = 1; s.valid = 1; s.dhi = 32'hDEAD; s.dlo = 32'hBEEF; step(s);
        s = idle(); s.rd = 1; step(s);

        // Divide commit colliding with a slot-2 write.
        s = idle(); s.start = 1; step(s);
        s = idle(); step(s);
        s.valid = 1; s.dhi = 32'h1; s.dlo = 32'h9;
        s.we2 = 1; s.hi2 = 32'h2; s.lo2 = 32'hA; step(s);
        s = idle(); s.rd = 1; step(s);

        // Write-back hazard on a slot-1 write.
        s = idle(); s.we1 = 1; s.hi1 = 32'h77; s.lo1 = 32'h78; s.rd = 1; step(s);
        s = idle(); s.rd = 1; step(s);

        // Random traffic; a new divide is only started when none is outstanding.
        for (int i = 0; i < 400; i++) begin
            s = idle();
            s.rst   = ($urandom_range(0, 99) < 2);
            s.we1   = ($urandom_range(0, 9) < 3);
            s.hi1   = $urandom(); s.lo1 = $urandom();
            s.we2   = ($urandom_range(0, 9) < 3);
            s.hi2   = $urandom(); s.lo2 = $urandom();
            s.start = !m_pend && ($urandom_range(0, 9) < 3);
            s.valid = m_pend ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 19) == 0);
            s.dhi   = $urandom(); s.dlo = $urandom();
            s.flush = ($urandom_range(0, 9) == 0);
            s.rd    = $urandom_range(0, 1);
            step(s);
        end

        s = idle(); step(s); step(s);
        repeat (3) @(posedge clk);
        chk("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
